// File: rtl/casper400g_pkg.sv
// casper400g_pkg: shared widths, arbiter state type and round-robin pick helper.
package casper400g_pkg;

    localparam int AXIS_DATA_W = 512;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
    localparam int MAX_PORTS   = 8;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // One-hot pick of the first requester strictly after ptr, wrapping at n; ptr itself ranks last.
    function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                     input logic [2:0] ptr,
                                                     input int n);
        logic [MAX_PORTS-1:0] g;
        int idx;
        g = '0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && g == '0 && req[idx[2:0]]) g[idx[2:0]] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/casper400g_axis_skid.sv
// casper400g_axis_skid: 2-entry AXIS register slice with a registered upstream ready.
module casper400g_axis_skid
    import casper400g_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              axis_clk,
    input  logic              axis_reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic [KEEP_W-1:0] i_tkeep,
    input  logic              i_tlast,
    input  logic              i_tuser,
    output logic              o_ready,
    output logic              o_tvalid,
    output logic [DATA_W-1:0] o_tdata,
    output logic [KEEP_W-1:0] o_tkeep,
    output logic              o_tlast,
    output logic              o_tuser,
    input  logic              i_tready
);

    localparam int W = DATA_W + KEEP_W + 2;

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         r_ready;
    logic         w_pop;
    logic [1:0]   w_cnt_nxt;

    assign o_tvalid  = r_cnt != 2'd0;
    assign o_ready   = r_ready;
    assign w_pop     = o_tvalid & i_tready;
    assign w_cnt_nxt = r_cnt + {1'b0, i_push} - {1'b0, w_pop};
    assign {o_tuser, o_tlast, o_tkeep, o_tdata} = r_mem[r_rd];

    // Ready looks at the occupancy after this cycle, so a push is never offered to a full slice.
    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= {i_tuser, i_tlast, i_tkeep, i_tdata};
                r_wr        <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_cnt_nxt != 2'd2;
        end
    end

endmodule

// File: rtl/casper400g_tx_arbiter.sv
// casper400g_tx_arbiter: packet-locked round-robin arbiter merging NUM_PORTS AXIS
// streams onto the single 400G TX path through a 2-entry skid.
module casper400g_tx_arbiter
    import casper400g_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = AXIS_DATA_W
) (
    input  logic                            axis_clk,
    input  logic                            axis_reset_n,
    input  logic                            enable,
    input  logic [NUM_PORTS*DATA_W-1:0]     s_axis_tdata,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    input  logic [NUM_PORTS-1:0]            s_axis_tuser,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_W-1:0]               m_axis_tdata,
    output logic [DATA_W/8-1:0]             m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    input  logic                            m_axis_tready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [31:0]                     tx_pkt_count
);

    localparam int KEEP_W = DATA_W / 8;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [NUM_PORTS-1:0] r_grant;
    logic [NUM_PORTS-1:0] w_grant_nxt;
    logic [2:0]           r_rr_ptr;
    logic [31:0]          r_pkt_count;
    logic [DATA_W-1:0]    w_tdata;
    logic [KEEP_W-1:0]    w_tkeep;
    logic                 w_tlast;
    logic                 w_tuser;
    logic [2:0]           w_gnt_idx;
    logic                 w_skid_ready;
    logic                 w_acc;
    logic                 w_last;
    logic [MAX_PORTS-1:0] w_req;
    logic [MAX_PORTS-1:0] w_pick;

    assign s_axis_tready = r_grant & {NUM_PORTS{w_skid_ready}};
    assign w_acc         = |(s_axis_tvalid & s_axis_tready);
    assign w_last        = w_acc & w_tlast;
    assign grant         = r_grant;
    assign tx_pkt_count  = r_pkt_count;

    always_comb begin
        w_tdata   = '0;
        w_tkeep   = '0;
        w_tlast   = 1'b0;
        w_tuser   = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant[i]) begin
                w_tdata   = w_tdata | s_axis_tdata[i*DATA_W +: DATA_W];
                w_tkeep   = w_tkeep | s_axis_tkeep[i*KEEP_W +: KEEP_W];
                w_tlast   = w_tlast | s_axis_tlast[i];
                w_tuser   = w_tuser | s_axis_tuser[i];
                w_gnt_idx = w_gnt_idx | 3'(i);
            end
        end
    end

    // The finishing port is masked: its tvalid on the last beat says nothing about a next packet.
    always_comb begin
        w_req                  = '0;
        w_req[NUM_PORTS-1:0]   = enable ? s_axis_tvalid & ~r_grant : '0;
        w_pick                 = rr_pick(w_req, r_state == IDLE ? r_rr_ptr : w_gnt_idx, NUM_PORTS);
        w_grant_nxt            = (r_state == IDLE || w_last) ? w_pick[NUM_PORTS-1:0] : r_grant;
        w_state_nxt            = (w_grant_nxt != '0) ? BUSY : IDLE;
    end

    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= 3'(NUM_PORTS - 1);
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_last) begin
                r_rr_ptr    <= w_gnt_idx;
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    casper400g_axis_skid #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) u_skid (
        .axis_clk     (axis_clk),
        .axis_reset_n (axis_reset_n),
        .i_push       (w_acc),
        .i_tdata      (w_tdata),
        .i_tkeep      (w_tkeep),
        .i_tlast      (w_tlast),
        .i_tuser      (w_tuser),
        .o_ready      (w_skid_ready),
        .o_tvalid     (m_axis_tvalid),
        .o_tdata      (m_axis_tdata),
        .o_tkeep      (m_axis_tkeep),
        .o_tlast      (m_axis_tlast),
        .o_tuser      (m_axis_tuser),
        .i_tready     (m_axis_tready)
    );

endmodule

// File: tb/tb_casper400g_tx_arbiter.sv
// tb_casper400g_tx_arbiter: table-driven single-packet check plus scoreboarded multi-port sequences.
module tb_casper400g_tx_arbiter;

    localparam int NP = 4;
    localparam int DW = 512;
    localparam int KW = 64;

    logic             axis_clk = 1'b0;
    logic             axis_reset_n = 1'b0;
    logic             enable = 1'b0;
    logic [NP*DW-1:0] s_axis_tdata = '0;
    logic [NP*KW-1:0] s_axis_tkeep = '0;
    logic [NP-1:0]    s_axis_tvalid = '0;
    logic [NP-1:0]    s_axis_tlast = '0;
    logic [NP-1:0]    s_axis_tuser = '0;
    logic [NP-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic             m_axis_tready = 1'b0;
    logic [NP-1:0]    grant;
    logic [31:0]      tx_pkt_count;

    always #5 axis_clk = ~axis_clk;

    casper400g_tx_arbiter #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
        .axis_clk(axis_clk), .axis_reset_n(axis_reset_n), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .grant(grant), .tx_pkt_count(tx_pkt_count)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } beat_t;

    typedef struct {
        logic          vld;
        logic          lst;
        logic [NP-1:0] e_gnt;
        logic [NP-1:0] e_rdy;
        logic          e_mv;
        logic          e_ml;
        logic [31:0]   e_cnt;
    } vec_t;

    beat_t         src_q [NP][$];
    beat_t         exp_q [$];
    int            out_port_q [$];
    vec_t          tv [6];
    logic [NP-1:0] src_on = '0;
    bit            auto_src = 1'b0;
    logic [NP-1:0] s_hs = '0;
    logic          m_hs = 1'b0;
    bit            stall_pend = 1'b0;
    logic [DW-1:0] stall_d;
    int            checks = 0, errors = 0;
    int            cyc = 0, occ = 0, max_occ = 0;
    int            m_beats = 0, first_m_cyc = 0, last_m_cyc = 0;
    int            acc_cnt [NP];
    logic          last_tuser = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        beat_t b;
        s_hs = s_axis_tvalid & s_axis_tready;
        m_hs = m_axis_tvalid & m_axis_tready;
        if (stall_pend) begin
            chk("stall_valid", m_axis_tvalid, 1);
            chk("stall_data", m_axis_tdata, stall_d);
        end
        if (occ == 2) chk("sready_when_full", s_axis_tready, 0);
        if (m_hs) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_beat: got data 0x%0h, expected no beat", m_axis_tdata[31:0]);
            end else begin
                b = exp_q.pop_front();
                chk("sb_tdata", m_axis_tdata, b.d);
                chk("sb_tkeep", m_axis_tkeep, b.k);
                chk("sb_tlast", m_axis_tlast, b.l);
                chk("sb_tuser", m_axis_tuser, b.u);
            end
            if (m_beats == 0) first_m_cyc = cyc;
            m_beats++;
            last_m_cyc = cyc;
            if (m_axis_tlast) begin
                out_port_q.push_back(int'(m_axis_tdata[23:16]));
                last_tuser = m_axis_tuser;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (s_hs[p]) begin
                b.d = s_axis_tdata[p*DW +: DW];
                b.k = s_axis_tkeep[p*KW +: KW];
                b.l = s_axis_tlast[p];
                b.u = s_axis_tuser[p];
                exp_q.push_back(b);
                acc_cnt[p]++;
            end
        end
        occ += $countones(s_hs) - int'(m_hs);
        if (occ > max_occ) max_occ = occ;
        stall_pend = m_axis_tvalid & ~m_axis_tready;
        stall_d = m_axis_tdata;
        cyc++;
    endtask

    task automatic drive_src();
        for (int p = 0; p < NP; p++) begin
            if (src_on[p] && src_q[p].size() > 0) begin
                s_axis_tvalid[p]          = 1'b1;
                s_axis_tdata[p*DW +: DW]  = src_q[p][0].d;
                s_axis_tkeep[p*KW +: KW]  = src_q[p][0].k;
                s_axis_tlast[p]           = src_q[p][0].l;
                s_axis_tuser[p]           = src_q[p][0].u;
            end else begin
                s_axis_tvalid[p] = 1'b0;
                s_axis_tlast[p]  = 1'b0;
                s_axis_tuser[p]  = 1'b0;
            end
        end
    endtask

    task automatic wait_neg();
        @(negedge axis_clk);
        sample();
    endtask

    task automatic wait_pos();
        @(posedge axis_clk);
        #1;
        if (auto_src) begin
            for (int p = 0; p < NP; p++) if (s_hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            drive_src();
        end
    endtask

    task automatic step();
        wait_neg();
        wait_pos();
    endtask

    task automatic add_pkt(input int p, input int n, input int id, input bit u_last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom();
            b.d[7:0]   = 8'(i);
            b.d[15:8]  = 8'(id);
            b.d[23:16] = 8'(p);
            b.l = (i == n - 1);
            b.k = b.l ? ({$urandom(), $urandom()} | 64'd1) : '1;
            b.u = u_last && b.l;
            src_q[p].push_back(b);
        end
    endtask

    task automatic run_until_out(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (out_port_q.size() < n && c < budget) begin
            step();
            c++;
        end
        chk(name, out_port_q.size(), n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int exp2 [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        tv[0] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'd0};
        tv[1] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 32'd0};
        tv[2] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 32'd0};
        tv[3] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 32'd0};
        tv[4] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'd1};
        tv[5] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'd1};
        for (int p = 0; p < NP; p++) acc_cnt[p] = 0;

        // reset state
        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_sready", s_axis_tready, 0);
        chk("rst_count", tx_pkt_count, 0);
        chk("rst_mdata", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
        axis_reset_n = 1'b1;
        enable = 1'b1;
        m_axis_tready = 1'b1;
        step();
        step();

        // single 3-beat packet on port 0, cycle by cycle
        for (int r = 0; r < 6; r++) begin
            s_axis_tvalid = {3'b000, tv[r].vld};
            s_axis_tlast  = {3'b000, tv[r].lst};
            s_axis_tkeep[KW-1:0] = '1;
            s_axis_tdata[31:0] = $urandom();
            s_axis_tdata[DW-1:DW-32] = 32'(r);
            wait_neg();
            chk($sformatf("t1_grant_r%0d", r), grant, tv[r].e_gnt);
            chk($sformatf("t1_sready_r%0d", r), s_axis_tready, tv[r].e_rdy);
            chk($sformatf("t1_mvalid_r%0d", r), m_axis_tvalid, tv[r].e_mv);
            if (tv[r].e_mv) chk($sformatf("t1_mlast_r%0d", r), m_axis_tlast, tv[r].e_ml);
            chk($sformatf("t1_count_r%0d", r), tx_pkt_count, tv[r].e_cnt);
            wait_pos();
        end
        chk("t1_sb_empty", exp_q.size(), 0);
        out_port_q.delete();
        auto_src = 1'b1;

        // all ports stream two 2-beat packets; rr_ptr is 0 after port 0's packet
        for (int p = 0; p < NP; p++) begin
            add_pkt(p, 2, 10, 1'b0);
            add_pkt(p, 2, 11, 1'b0);
        end
        m_beats = 0;
        src_on = '1;
        drive_src();
        run_until_out(8, 60, "t2_pkts_out");
        for (int i = 0; i < 8; i++) chk($sformatf("t2_order_%0d", i), out_port_q[i], exp2[i]);
        chk("t2_beats", m_beats, 16);
        chk("t2_no_gap", last_m_cyc - first_m_cyc, 15);
        chk("t2_count", tx_pkt_count, 9);
        step();
        chk("t2_idle_grant", grant, 0);

        // 8-beat packet with alternating downstream ready
        out_port_q.delete();
        m_beats = 0;
        max_occ = 0;
        add_pkt(0, 8, 20, 1'b0);
        drive_src();
        c = 0;
        while (out_port_q.size() < 1 && c < 60) begin
            step();
            m_axis_tready = ~m_axis_tready;
            c++;
        end
        chk("t3_pkt_out", out_port_q.size(), 1);
        chk("t3_beats", m_beats, 8);
        chk("t3_skid_filled", max_occ, 2);
        chk("t3_sb_empty", exp_q.size(), 0);
        m_axis_tready = 1'b1;
        step();

        // enable dropped mid-packet on port 2 while port 3 waits
        out_port_q.delete();
        acc_cnt[2] = 0;
        acc_cnt[3] = 0;
        add_pkt(2, 5, 30, 1'b0);
        add_pkt(3, 2, 31, 1'b0);
        drive_src();
        c = 0;
        while (acc_cnt[2] < 2 && c < 20) begin
            step();
            c++;
        end
        chk("t4_two_beats", acc_cnt[2], 2);
        enable = 1'b0;
        run_until_out(1, 30, "t4_p2_out");
        chk("t4_first_port", out_port_q[0], 2);
        for (int i = 0; i < 5; i++) step();
        chk("t4_grant_held_off", grant, 0);
        chk("t4_p3_not_served", acc_cnt[3], 0);
        chk("t4_sready_off", s_axis_tready, 0);
        enable = 1'b1;
        run_until_out(2, 30, "t4_p3_out");
        chk("t4_second_port", out_port_q[1], 3);
        chk("t4_count", tx_pkt_count, 12);

        // async reset in the middle of a port 1 packet
        out_port_q.delete();
        acc_cnt[1] = 0;
        add_pkt(1, 6, 40, 1'b0);
        drive_src();
        c = 0;
        while (acc_cnt[1] < 3 && c < 20) begin
            step();
            c++;
        end
        chk("t5_pre_mvalid", m_axis_tvalid, 1);
        axis_reset_n = 1'b0;
        #1;
        chk("t5_mvalid", m_axis_tvalid, 0);
        chk("t5_grant", grant, 0);
        chk("t5_count", tx_pkt_count, 0);
        chk("t5_sready", s_axis_tready, 0);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        occ = 0;
        stall_pend = 1'b0;
        drive_src();
        step();
        step();
        add_pkt(0, 2, 41, 1'b0);
        add_pkt(1, 2, 42, 1'b0);
        drive_src();
        axis_reset_n = 1'b1;
        c = 0;
        while (grant == 0 && c < 5) begin
            step();
            c++;
        end
        chk("t5_first_grant", grant, 4'b0001);
        run_until_out(2, 30, "t5_pkts_out");
        chk("t5_order_0", out_port_q[0], 0);
        chk("t5_order_1", out_port_q[1], 1);
        chk("t5_count_after", tx_pkt_count, 2);

        // counter wrap and tuser on the last beat
        step();
        out_port_q.delete();
        force dut.r_pkt_count = 32'hFFFF_FFFF;
        step();
        release dut.r_pkt_count;
        add_pkt(1, 2, 50, 1'b1);
        drive_src();
        run_until_out(1, 20, "t6_pkt_out");
        chk("t6_count_wrap", tx_pkt_count, 0);
        chk("t6_tuser_last", last_tuser, 1);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
